vec_streamer: RTL and testbench
===============================

VEC_STREAMER -- requirements
Module: vec_streamer

Interface
REQ-001 Parameter DEPTH, default 64, meaning maximum vector length in elements (power of two, 2..256).
REQ-002 Parameter NPASS, default 2, meaning number of times a loaded vector is replayed per start (1..3).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  load strobe; element accepted when wr_en && wr_ready.
REQ-006 wr_data  input  16  Q7.8 signed element to load.
REQ-007 wr_last  input  1  marks final element of the vector being loaded.
REQ-008 wr_ready  output  1  high in IDLE and LOAD only.
REQ-009 start  input  1  one-cycle request to begin replay; honoured only in LOADED.
REQ-010 reset_vec  output  1  one-cycle pulse preceding each pass; clears the downstream max accumulator.
REQ-011 out_valid  output  1  out_data valid this cycle.
REQ-012 out_data  output  16  Q7.8 element, bit-exact copy of loaded value.
REQ-013 out_last  output  1  high with final element of each pass.
REQ-014 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-015 pass_idx  output  2  current pass number, 0-based, valid while out_valid.
REQ-016 done  output  1  one-cycle pulse after final transfer of final pass.
REQ-017 ovf  output  1  sticky; set when a load exceeds DEPTH; cleared by rst or next accepted first element.

Function
REQ-018 FSM states IDLE, LOAD, LOADED, PREP, STREAM, DONE; reset state IDLE.
REQ-019 IDLE: accepted write stores at addr 0, wr_cnt=1; -> LOAD, or -> LOADED if wr_last.
REQ-020 LOAD: each accepted write stores at wr_cnt, increments; wr_last -> LOADED with len = wr_cnt+1.
REQ-021 Write when wr_cnt==DEPTH: data discarded, ovf set, wr_cnt held; wr_last still -> LOADED with len=DEPTH.
REQ-022 LOADED: start -> PREP, pass=0; start ignored in all other states; new writes not accepted.
REQ-023 PREP: reset_vec=1 for exactly one cycle, out_valid=0, rd_ptr=0; -> STREAM next cycle.
REQ-024 STREAM: out_valid=1 continuously; out_data=mem[rd_ptr] registered, no bubble between consecutive transfers while out_ready=1.
REQ-025 out_data, out_last, pass_idx held stable while out_valid && !out_ready.
REQ-026 out_last=1 iff rd_ptr==len-1.
REQ-027 Transfer with out_last: if pass<NPASS-1 -> PREP with pass+1, else -> DONE.
REQ-028 DONE: done=1 for one cycle; -> IDLE; buffer contents retained but len invalidated.
REQ-029 len=1 vector: each pass is one beat with out_last=1.
REQ-030 start coincident with rst: rst wins.
REQ-031 Throughput: NPASS*(len+1) cycles from PREP to DONE with out_ready=1.
REQ-032 Storage: DEPTH x 16 registers or inferred synchronous RAM; read latency hidden by prefetch so REQ-024 holds.

Reset
REQ-033 rst=1 at any edge: state IDLE, wr_cnt=0, rd_ptr=0, pass=0, len=0, ovf=0, outputs reset_vec/out_valid/out_last/done=0, out_data=16'h0000, pass_idx=0; wr_ready=1 the cycle after rst deasserts.
REQ-034 rst mid-STREAM aborts immediately: no done pulse, no further out_valid; memory contents are don't-care.

Verification
REQ-035 Load 4 elements {0x0100, 0xFF00, 0x0280, 0x8000}, start, out_ready=1 -> reset_vec at cycle 1, 4 beats in order, out_last on beat 4, repeat with pass_idx=1, done pulse; total 10 cycles PREP->DONE.
REQ-036 Same vector with out_ready toggling 1,0,0,1 -> no data lost or duplicated; out_data stable during stalls; order preserved.
REQ-037 Load single element 0x7FFF with wr_last on first write -> each pass one beat, out_last=1, done after 4 cycles.
REQ-038 Load DEPTH+3 elements -> ovf=1, replay emits exactly DEPTH beats per pass, last = element DEPTH-1.
REQ-039 Assert rst during pass 0 beat 2 -> next cycle out_valid=0, wr_ready=1, state IDLE, no done.
REQ-040 start pulsed in IDLE and during STREAM -> ignored; wr_en during STREAM -> wr_ready=0, buffer unchanged.

Source files
------------

// File: rtl/vec_streamer.sv
// Vector replay engine: loads a Q7.8 vector into local storage, then streams it
// NPASS times, each pass preceded by a one-cycle reset_vec pulse.
module vec_streamer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned NPASS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        start,
  output logic        reset_vec,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [1:0]  pass_idx,
  output logic        done,
  output logic        ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_PREP,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_mem [DEPTH];
  logic [CW-1:0]   r_wr_cnt;
  logic [CW-1:0]   r_len;
  logic [AW-1:0]   r_rd_ptr;
  logic [1:0]      r_pass;
  logic            r_ovf;
  logic [15:0]     r_out_data;

  logic            w_wr_acc;
  logic            w_full;
  logic            w_store;
  logic [AW-1:0]   w_wr_addr;
  logic            w_is_last;
  logic            w_xfer;
  logic            w_final_pass;
  logic [AW-1:0]   w_rd_next;

  assign w_wr_acc     = wr_en && wr_ready;
  assign w_full       = (r_wr_cnt == CW'(DEPTH));
  assign w_store      = w_wr_acc && ((r_state == S_IDLE) || !w_full);
  assign w_wr_addr    = (r_state == S_IDLE) ? '0 : r_wr_cnt[AW-1:0];
  assign w_is_last    = (r_state == S_STREAM) && ({1'b0, r_rd_ptr} == (r_len - CW'(1)));
  assign w_xfer       = out_valid && out_ready;
  assign w_final_pass = (r_pass == 2'(NPASS - 1));
  assign w_rd_next    = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    wr_ready  = 1'b0;
    reset_vec = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready = 1'b1;
        if (w_wr_acc) w_next = wr_last ? S_LOADED : S_LOAD;
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        if (w_wr_acc && wr_last) w_next = S_LOADED;
      end
      S_LOADED: begin
        if (start) w_next = S_PREP;
      end
      S_PREP: begin
        reset_vec = 1'b1;
        w_next    = S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        if (w_xfer && w_is_last) w_next = w_final_pass ? S_DONE : S_PREP;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_last = w_is_last;
  assign out_data = r_out_data;
  assign pass_idx = r_pass;
  assign ovf      = r_ovf;

  always_ff @(posedge clk) begin
    if (w_store) r_mem[w_wr_addr] <= wr_data;
  end

  // out_data is prefetched in PREP and on each non-final transfer, so the
  // next element is already registered when the consumer accepts the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt   <= '0;
      r_len      <= '0;
      r_rd_ptr   <= '0;
      r_pass     <= '0;
      r_ovf      <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_acc) begin
            r_wr_cnt <= CW'(1);
            r_ovf    <= 1'b0;
            if (wr_last) r_len <= CW'(1);
          end
        end
        S_LOAD: begin
          if (w_wr_acc) begin
            if (w_full) r_ovf    <= 1'b1;
            else        r_wr_cnt <= r_wr_cnt + CW'(1);
            if (wr_last) r_len <= w_full ? CW'(DEPTH) : (r_wr_cnt + CW'(1));
          end
        end
        S_LOADED: begin
          if (start) r_pass <= '0;
        end
        S_PREP: begin
          r_rd_ptr   <= '0;
          r_out_data <= r_mem[0];
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (!w_is_last) begin
              r_rd_ptr   <= w_rd_next;
              r_out_data <= r_mem[w_rd_next];
            end else if (!w_final_pass) begin
              r_pass <= r_pass + 2'd1;
            end
          end
        end
        S_DONE: begin
          r_len  <= '0;
          r_pass <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_streamer.sv
// Self-checking bench for vec_streamer: directed cases plus randomized vectors,
// backpressure and ignored-input pokes, checked against a queue-based replay model.
module tb_vec_streamer;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NPASS = 2;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_last, start, out_ready;
  logic [15:0] wr_data;
  logic        wr_ready, reset_vec, out_valid, out_last, done, ovf;
  logic [15:0] out_data;
  logic [1:0]  pass_idx;

  vec_streamer #(.DEPTH(DEPTH), .NPASS(NPASS)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .start(start), .reset_vec(reset_vec),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .pass_idx(pass_idx), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] vec[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_data = '0; start = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pass_idx", pass_idx, 0);
    check("rst_done", done, 0);
    check("rst_reset_vec", reset_vec, 0);
    check("rst_ovf", ovf, 0);
  endtask

  task automatic load_vec;
    for (int i = 0; i < vec.size(); i++) begin
      check("ld_wr_ready", wr_ready, 1);
      wr_en = 1'b1; wr_data = vec[i]; wr_last = (i == vec.size() - 1);
      tick;
      if (i == 0) check("ld_ovf_clear", ovf, 0);
    end
    wr_en = 1'b0; wr_last = 1'b0;
    check("ld_ovf", ovf, (vec.size() > DEPTH) ? 1 : 0);
    check("ld_wr_ready_loaded", wr_ready, 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run(input int mode, input bit poke);
    int L, total, k, nrst, cyc, t0, budget;
    bit got_done, rdy;
    L      = (vec.size() > DEPTH) ? DEPTH : vec.size();
    total  = NPASS * L;
    k      = 0; nrst = 0; cyc = 0; t0 = -1; got_done = 1'b0;
    budget = NPASS * (L + 1) * 8 + 40;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (!got_done && cyc < budget) begin
      if (reset_vec) begin
        nrst++;
        check("rv_no_valid", out_valid, 0);
        if (t0 < 0) t0 = cyc;
      end
      if (done) begin
        got_done = 1'b1;
        if (mode == 0) check("done_latency", cyc - t0, NPASS * (L + 1));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      if (out_valid) begin
        check("strm_wr_ready", wr_ready, 0);
        if (k >= total) begin
          check("extra_beat", k, total);
        end else begin
          check("out_data", out_data, vec[k % L]);
          check("out_last", out_last, ((k % L) == L - 1) ? 1 : 0);
          check("pass_idx", pass_idx, k / L);
        end
        if (rdy) k++;
      end
      out_ready = rdy;
      if (poke && !got_done) begin
        start   = 1'($urandom);
        wr_en   = 1'b1;
        wr_data = 16'($urandom);
        wr_last = 1'($urandom);
      end else begin
        start = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
      end
      tick;
      cyc++;
    end
    start = 1'b0; wr_en = 1'b0; wr_last = 1'b0; out_ready = 1'b1;
    if (!got_done) check("done_timeout", 0, 1);
    check("beat_count", k, total);
    check("reset_vec_count", nrst, NPASS);
    check("post_done_pulse", done, 0);
    check("post_out_valid", out_valid, 0);
    check("post_wr_ready", wr_ready, 1);
    check("post_ovf_sticky", ovf, (vec.size() > DEPTH) ? 1 : 0);
  endtask

  task automatic rand_vec(input int n);
    vec.delete();
    for (int i = 0; i < n; i++) vec.push_back(16'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset;

    // start in IDLE is ignored
    start = 1'b1; tick; start = 1'b0;
    check("idle_start_rv", reset_vec, 0);
    check("idle_start_valid", out_valid, 0);
    check("idle_start_ready", wr_ready, 1);
    tick;
    check("idle_start_valid2", out_valid, 0);

    vec = '{16'h0100, 16'hFF00, 16'h0280, 16'h8000};
    load_vec; run(0, 1'b0);
    load_vec; run(1, 1'b0);

    vec = '{16'h7FFF};
    load_vec; run(0, 1'b0);

    rand_vec(DEPTH + 3);
    load_vec; run(0, 1'b0);

    // start and writes during replay must be ignored
    rand_vec(6);
    load_vec; run(2, 1'b1);

    // reset during pass 0, beat 2
    vec = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    load_vec;
    start = 1'b1; tick; start = 1'b0;
    check("abort_prep", reset_vec, 1);
    out_ready = 1'b1;
    tick;
    check("abort_beat1", out_data, 16'h1111);
    tick;
    check("abort_beat2", out_data, 16'h2222);
    check("abort_beat2_valid", out_valid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_wr_ready", wr_ready, 1);
    check("abort_done", done, 0);
    check("abort_out_data", out_data, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("abort_quiet_valid", out_valid, 0);
      check("abort_quiet_done", done, 0);
    end

    for (int it = 0; it < 10; it++) begin
      rand_vec(($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 2, DEPTH + 5)
                                          : $urandom_range(1, 12));
      load_vec;
      run($urandom_range(0, 2), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
